// File: rtl/wb_arb_rr.sv
// wb_arb_rr: round-robin Wishbone B3 shared-bus arbiter with base/mask slave decode.
// One master owns the bus per cyc. The slave is chosen once per cyc and held.
// Unmapped addresses and stalled slaves are answered with err.
module wb_arb_rr #(
  parameter int                  NUM_M   = 2,
  parameter int                  NUM_S   = 4,
  parameter int                  DW      = 64,
  parameter int                  AW      = 32,
  parameter logic [NUM_S*AW-1:0] S_BASE  = {NUM_S{32'h0}},
  parameter logic [NUM_S*AW-1:0] S_MASK  = {NUM_S{32'hFFFFF000}},
  parameter int                  TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*AW-1:0]     m_adr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*(DW/8)-1:0] m_sel_i,
  input  logic [NUM_M*3-1:0]      m_cti_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_M-1:0]        m_rty_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  output logic                    s_we_o,
  output logic [2:0]              s_cti_o,
  output logic [NUM_S-1:0]        s_cyc_o,
  output logic [NUM_S-1:0]        s_stb_o,
  input  logic [NUM_S*DW-1:0]     s_dat_i,
  input  logic [NUM_S-1:0]        s_ack_i,
  input  logic [NUM_S-1:0]        s_err_i,
  input  logic [NUM_S-1:0]        s_rty_i,
  output logic [NUM_M-1:0]        gnt_o,
  output logic                    timeout_o
);

  localparam int MIW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SIW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [MIW-1:0]   ptr_q, ptr_d;
  logic [MIW-1:0]   gidx_q, gidx_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [SIW-1:0]   ssel_q, ssel_d;
  logic             nomatch_q, nomatch_d;
  logic             nm_err_q, nm_err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [AW-1:0]    m_adr [NUM_M];
  logic [DW-1:0]    m_dat [NUM_M];
  logic [DW/8-1:0]  m_sel [NUM_M];
  logic [2:0]       m_cti [NUM_M];
  logic [DW-1:0]    s_dat [NUM_S];
  logic [AW-1:0]    s_base [NUM_S];
  logic [AW-1:0]    s_mask [NUM_S];

  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack_m
    assign m_adr[i] = m_adr_i[i*AW +: AW];
    assign m_dat[i] = m_dat_i[i*DW +: DW];
    assign m_sel[i] = m_sel_i[i*(DW/8) +: DW/8];
    assign m_cti[i] = m_cti_i[i*3 +: 3];
  end

  for (genvar i = 0; i < NUM_S; i++) begin : g_unpack_s
    assign s_dat[i]  = s_dat_i[i*DW +: DW];
    assign s_base[i] = S_BASE[i*AW +: AW];
    assign s_mask[i] = S_MASK[i*AW +: AW];
  end

  logic           gcyc, gstb, active, resp, wd_en, to_hit;
  logic           req_found, dec_hit;
  logic [MIW-1:0] req_idx, cand;
  logic [SIW-1:0] dec_idx;

  assign gcyc   = m_cyc_i[gidx_q];
  assign gstb   = m_stb_i[gidx_q];
  assign active = (state_q == ACTIVE);
  assign resp   = s_ack_i[ssel_q] | s_err_i[ssel_q] | s_rty_i[ssel_q];
  assign wd_en  = (TIMEOUT > 0) && active && !nomatch_q && gcyc && gstb;
  assign to_hit = wd_en && (cnt_q == CW'(TIMEOUT));
  assign gnt_o  = gnt_q;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = MIW'((int'(ptr_q) + i) % NUM_M);
      if (!req_found && m_cyc_i[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Address decode of the granted master; the lowest matching slave wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if ((m_adr[gidx_q] & s_mask[i]) == (s_base[i] & s_mask[i])) begin
        dec_hit = 1'b1;
        dec_idx = SIW'(i);
      end
    end
  end

  // Next state: grant in IDLE, latch slave in DECODE, run and watch in ACTIVE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    gnt_d     = gnt_q;
    ssel_d    = ssel_q;
    nomatch_d = nomatch_q;
    nm_err_d  = 1'b0;
    cnt_d     = '0;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          gidx_d  = req_idx;
          gnt_d   = NUM_M'(1) << req_idx;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ssel_d    = dec_idx;
        nomatch_d = !dec_hit;
        state_d   = ACTIVE;
      end
      ACTIVE: begin
        if (!gcyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == MIW'(NUM_M - 1)) ? '0 : gidx_q + MIW'(1);
        end else begin
          nm_err_d = nomatch_q && gstb && !nm_err_q;
          if (wd_en && !resp && !to_hit) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      ssel_q    <= '0;
      nomatch_q <= 1'b0;
      nm_err_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      gnt_q     <= gnt_d;
      ssel_q    <= ssel_d;
      nomatch_q <= nomatch_d;
      nm_err_q  <= nm_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Bus routing: broadcast the owner's request, steer one slave's reply back.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cti_o   = '0;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    m_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    timeout_o = 1'b0;
    if (state_q != IDLE) begin
      s_adr_o = m_adr[gidx_q];
      s_dat_o = m_dat[gidx_q];
      s_sel_o = m_sel[gidx_q];
      s_we_o  = m_we_i[gidx_q];
      s_cti_o = m_cti[gidx_q];
    end
    if (active) begin
      if (nomatch_q) begin
        m_err_o[gidx_q] = nm_err_q;
      end else begin
        s_cyc_o[ssel_q] = gcyc;
        s_stb_o[ssel_q] = gstb & ~to_hit;
        m_dat_o         = s_dat[ssel_q];
        m_ack_o[gidx_q] = s_ack_i[ssel_q] & ~to_hit;
        m_err_o[gidx_q] = s_err_i[ssel_q] | to_hit;
        m_rty_o[gidx_q] = s_rty_i[ssel_q] & ~to_hit;
        timeout_o       = to_hit;
      end
    end
  end

endmodule
